hash_cmd_scheduler: RTL and testbench
=====================================

HASH_CMD_SCHEDULER -- requirements
Module: hash_cmd_scheduler

Interface
REQ-001 SHALL have parameters: KEY_WIDTH, default 32, key width; VALUE_WIDTH, default 32, value width; TAG_WIDTH, default 4, request tag width; FIFO_DEPTH, default 4, command queue depth (power of 2, >=2); TIMEOUT_CYCLES, default 8, response wait limit.
REQ-002 SHALL have ports:
 clk  in  1  single clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 cmd_valid  in  1  command offered
 cmd_ready  out  1  command accepted when high with cmd_valid
 cmd_op  in  2  0=READ, 1=WRITE, 2=DELETE, 3=illegal
 cmd_key  in  KEY_WIDTH  key
 cmd_value  in  VALUE_WIDTH  write value
 cmd_tag  in  TAG_WIDTH  caller tag
 ht_wr_en, ht_rd_en, ht_del_en  out  1 each  one-cycle strobes to downstream hash table
 ht_key  out  KEY_WIDTH  key for the strobed operation
 ht_value  out  VALUE_WIDTH  write value
 ht_wr_done, ht_wr_collision, ht_rd_valid, ht_rd_miss, ht_del_done  in  1 each  hash table result strobes
 ht_rd_value  in  VALUE_WIDTH  read data
 rsp_valid  out  1  response available
 rsp_ready  in  1  response consumed when high with rsp_valid
 rsp_tag  out  TAG_WIDTH  tag of the originating command
 rsp_op  out  2  op of the originating command
 rsp_status  out  2  0=OK, 1=MISS, 2=FULL, 3=ERROR
 rsp_value  out  VALUE_WIDTH  read data; 0 for all other ops and statuses
 busy  out  1  high when FIFO is non-empty or FSM is not IDLE

Function
REQ-003 cmd_ready SHALL equal !fifo_full; a handshake SHALL push {op,key,value,tag} into the FIFO in the same cycle.
REQ-004 A push while full SHALL be impossible; a simultaneous push and pop on a full FIFO SHALL NOT be accepted, because cmd_ready is low.
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-006 IDLE: if the FIFO is non-empty, pop the head into a command register and go to ISSUE; otherwise stay.
REQ-007 ISSUE (one cycle): assert exactly the one ht_*_en matching op, with ht_key/ht_value from the command register; clear the timeout counter; go to WAIT. For op 3, assert no strobe, set status ERROR and go directly to RESP.
REQ-008 WAIT: the timeout counter increments each cycle. Capture the first matching strobe and go to RESP:
 - WRITE: ht_wr_done -> OK (including when ht_wr_collision is also high); ht_wr_collision without ht_wr_done -> FULL.
 - READ: ht_rd_valid -> OK, rsp_value = ht_rd_value; ht_rd_miss -> MISS.
 - DELETE: ht_del_done -> OK.
REQ-009 Strobes not matching the in-flight op SHALL be ignored.
REQ-010 If no matching strobe arrives after TIMEOUT_CYCLES cycles in WAIT, the FSM SHALL go to RESP with status ERROR.
REQ-011 RESP: rsp_valid SHALL be high and all rsp_* fields SHALL be stable until rsp_ready; on handshake go to IDLE.
REQ-012 ht_*_en SHALL be registered outputs, high for exactly one cycle per command, never asserted in IDLE, WAIT or RESP.
REQ-013 At most one command SHALL be in flight, so response order equals command acceptance order.
REQ-014 Minimum latency from accept into an empty FIFO to rsp_valid SHALL be 4 cycles: pop, issue, downstream register, capture.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-016 While rst_n is low, asynchronously: FSM=IDLE, FIFO empty, cmd_ready=0, all ht_*_en=0, ht_key=0, ht_value=0, rsp_valid=0, rsp_tag=0, rsp_op=0, rsp_status=0, rsp_value=0, busy=0.
REQ-017 cmd_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-018 Reset mid-operation SHALL discard queued and in-flight commands with no response.

Structure
REQ-019 Package hash_cmd_pkg SHALL hold the op enum, the status enum, the FSM state enum, and the default parameter constants.
REQ-020 The FIFO SHALL be a separate sub-module hash_cmd_fifo (synchronous, parameterised width and depth, full/empty flags); all other logic SHALL be in hash_cmd_scheduler.

Verification
REQ-021 WRITE key=0x1234, value=0xCAFE, tag=1; model strobes ht_wr_done one cycle after ht_wr_en -> rsp tag=1, op=1, status=OK, value=0, rsp_valid 4 cycles after accept.
REQ-022 READ key=0x1234, tag=2; ht_rd_valid with ht_rd_value=0xCAFE -> status OK, value 0xCAFE; then READ key=0x9999 with ht_rd_miss -> status MISS, value 0.
REQ-023 Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready low after 4 pushes plus 1 in flight; release rsp_ready -> 5 responses in tag order.
REQ-024 WRITE with ht_wr_collision=1 and ht_wr_done=0 -> FULL; cmd_op=3 -> ERROR with no ht_* strobe.
REQ-025 READ with the hash table silent -> ERROR after 8 WAIT cycles; next command proceeds normally.
REQ-026 Assert rst_n low during WAIT with 2 commands queued -> all outputs at reset values; no stale response after release.

Source files
------------

// File: rtl/hash_cmd_pkg.sv
// Shared types and default parameters for the hash command scheduler.
// Contents: command op encoding, response status encoding, scheduler FSM
// states and the default parameter constants used by the top level.
package hash_cmd_pkg;

    localparam int DEF_KEY_WIDTH      = 32;
    localparam int DEF_VALUE_WIDTH    = 32;
    localparam int DEF_TAG_WIDTH      = 4;
    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 8;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_DELETE  = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_MISS  = 2'd1,
        ST_FULL  = 2'd2,
        ST_ERROR = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/hash_cmd_fifo.sv
// Synchronous command FIFO.
// Ports: clk, rst_n (async active-low), push/wr_data (write side),
//        pop/rd_data (read side, rd_data shows the head combinationally),
//        full/empty flags.
// Pushes while full and pops while empty are dropped. DEPTH must be a
// power of two so the pointers wrap naturally.
module hash_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/hash_cmd_scheduler.sv
// Hash table command scheduler: queues commands, issues them one at a time
// to a downstream hash table, waits for the matching result strobe (or a
// timeout) and returns a tagged response.
// Ports: clk, rst_n (async active-low); cmd_* command handshake in;
//        ht_* strobes/key/value out and ht_* result strobes in;
//        rsp_* response handshake out; busy.
//
// state  | meaning
// IDLE   | no command in flight; pops the FIFO head when one is queued
// ISSUE  | ht_*_en strobe is high this cycle; timeout counter cleared
// WAIT   | waiting for the result strobe matching the in-flight op
// RESP   | response held on rsp_* until rsp_ready
module hash_cmd_scheduler
    import hash_cmd_pkg::*;
#(
    parameter int KEY_WIDTH      = DEF_KEY_WIDTH,
    parameter int VALUE_WIDTH    = DEF_VALUE_WIDTH,
    parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [KEY_WIDTH-1:0]   cmd_key,
    input  logic [VALUE_WIDTH-1:0] cmd_value,
    input  logic [TAG_WIDTH-1:0]   cmd_tag,
    output logic                   ht_wr_en,
    output logic                   ht_rd_en,
    output logic                   ht_del_en,
    output logic [KEY_WIDTH-1:0]   ht_key,
    output logic [VALUE_WIDTH-1:0] ht_value,
    input  logic                   ht_wr_done,
    input  logic                   ht_wr_collision,
    input  logic                   ht_rd_valid,
    input  logic                   ht_rd_miss,
    input  logic                   ht_del_done,
    input  logic [VALUE_WIDTH-1:0] ht_rd_value,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    output logic [1:0]             rsp_op,
    output logic [1:0]             rsp_status,
    output logic [VALUE_WIDTH-1:0] rsp_value,
    output logic                   busy
);

    localparam int ENTRY_W = 2 + KEY_WIDTH + VALUE_WIDTH + TAG_WIDTH;
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e                 state;
    op_e                    cmd_op_q;
    logic [TAG_WIDTH-1:0]   cmd_tag_q;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   run_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [ENTRY_W-1:0]     fifo_wr_data;
    logic [ENTRY_W-1:0]     fifo_rd_data;

    logic [1:0]             head_op;
    logic [KEY_WIDTH-1:0]   head_key;
    logic [VALUE_WIDTH-1:0] head_value;
    logic [TAG_WIDTH-1:0]   head_tag;

    logic                   wait_hit;
    status_e                wait_status;
    logic [VALUE_WIDTH-1:0] wait_value;

    // run_q holds cmd_ready low during reset and for the edge that ends it.
    assign cmd_ready    = run_q && !fifo_full;
    assign fifo_push    = cmd_valid && cmd_ready;
    assign fifo_pop     = (state == S_IDLE) && !fifo_empty;
    assign fifo_wr_data = {cmd_op, cmd_key, cmd_value, cmd_tag};
    assign busy         = (state != S_IDLE) || !fifo_empty;

    assign head_op    = fifo_rd_data[ENTRY_W-1 -: 2];
    assign head_key   = fifo_rd_data[TAG_WIDTH+VALUE_WIDTH +: KEY_WIDTH];
    assign head_value = fifo_rd_data[TAG_WIDTH +: VALUE_WIDTH];
    assign head_tag   = fifo_rd_data[TAG_WIDTH-1:0];

    hash_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Only strobes belonging to the in-flight op are considered. A write
    // that reports done wins over a simultaneous collision.
    always_comb begin
        wait_hit    = 1'b0;
        wait_status = ST_OK;
        wait_value  = '0;
        case (cmd_op_q)
            OP_WRITE: begin
                if (ht_wr_done) begin
                    wait_hit = 1'b1;
                end else if (ht_wr_collision) begin
                    wait_hit    = 1'b1;
                    wait_status = ST_FULL;
                end
            end
            OP_READ: begin
                if (ht_rd_valid) begin
                    wait_hit   = 1'b1;
                    wait_value = ht_rd_value;
                end else if (ht_rd_miss) begin
                    wait_hit    = 1'b1;
                    wait_status = ST_MISS;
                end
            end
            OP_DELETE: wait_hit = ht_del_done;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_op_q   <= OP_READ;
            cmd_tag_q  <= '0;
            tmo_cnt    <= '0;
            run_q      <= 1'b0;
            ht_wr_en   <= 1'b0;
            ht_rd_en   <= 1'b0;
            ht_del_en  <= 1'b0;
            ht_key     <= '0;
            ht_value   <= '0;
            rsp_valid  <= 1'b0;
            rsp_tag    <= '0;
            rsp_op     <= '0;
            rsp_status <= '0;
            rsp_value  <= '0;
        end else begin
            run_q     <= 1'b1;
            ht_wr_en  <= 1'b0;
            ht_rd_en  <= 1'b0;
            ht_del_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Strobes are loaded on the pop edge so they are high
                    // exactly during ISSUE.
                    if (!fifo_empty) begin
                        cmd_op_q  <= op_e'(head_op);
                        cmd_tag_q <= head_tag;
                        ht_key    <= head_key;
                        ht_value  <= head_value;
                        ht_wr_en  <= (head_op == OP_WRITE);
                        ht_rd_en  <= (head_op == OP_READ);
                        ht_del_en <= (head_op == OP_DELETE);
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    if (cmd_op_q == OP_ILLEGAL) begin
                        rsp_valid  <= 1'b1;
                        rsp_tag    <= cmd_tag_q;
                        rsp_op     <= cmd_op_q;
                        rsp_status <= ST_ERROR;
                        rsp_value  <= '0;
                        state      <= S_RESP;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_hit) begin
                        rsp_valid  <= 1'b1;
                        rsp_tag    <= cmd_tag_q;
                        rsp_op     <= cmd_op_q;
                        rsp_status <= wait_status;
                        rsp_value  <= wait_value;
                        state      <= S_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_valid  <= 1'b1;
                        rsp_tag    <= cmd_tag_q;
                        rsp_op     <= cmd_op_q;
                        rsp_status <= ST_ERROR;
                        rsp_value  <= '0;
                        state      <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_cmd_scheduler.sv
module tb_hash_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_key = '0;
    logic [31:0] cmd_value = '0;
    logic [3:0]  cmd_tag = '0;
    logic        ht_wr_en, ht_rd_en, ht_del_en;
    logic [31:0] ht_key, ht_value;
    logic        ht_wr_done = 1'b0, ht_wr_collision = 1'b0;
    logic        ht_rd_valid = 1'b0, ht_rd_miss = 1'b0, ht_del_done = 1'b0;
    logic [31:0] ht_rd_value = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_op, rsp_status;
    logic [31:0] rsp_value;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // hash table model controls
    logic        silent = 1'b0;
    logic        noise = 1'b0;
    logic        rd_miss_mode = 1'b0;
    logic [1:0]  wr_mode = 2'd0;   // 0 done, 1 collision only, 2 done+collision
    logic [31:0] rd_data = '0;

    // hash table model observations
    int          pend_cnt = 0;
    logic [1:0]  pend_op = '0;
    int          strobe_cnt = 0;
    int          multi_strobe = 0;
    logic [1:0]  seen_op = '0;
    logic [31:0] seen_key = '0;
    logic [31:0] seen_val = '0;

    always #5 clk = ~clk;

    hash_cmd_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_key         (cmd_key),
        .cmd_value       (cmd_value),
        .cmd_tag         (cmd_tag),
        .ht_wr_en        (ht_wr_en),
        .ht_rd_en        (ht_rd_en),
        .ht_del_en       (ht_del_en),
        .ht_key          (ht_key),
        .ht_value        (ht_value),
        .ht_wr_done      (ht_wr_done),
        .ht_wr_collision (ht_wr_collision),
        .ht_rd_valid     (ht_rd_valid),
        .ht_rd_miss      (ht_rd_miss),
        .ht_del_done     (ht_del_done),
        .ht_rd_value     (ht_rd_value),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_tag         (rsp_tag),
        .rsp_op          (rsp_op),
        .rsp_status      (rsp_status),
        .rsp_value       (rsp_value),
        .busy            (busy)
    );

    // Hash table model: answers one cycle after the strobe (two with noise,
    // where the first WAIT cycle carries only strobes of other ops).
    always @(negedge clk) begin
        ht_wr_done      = 1'b0;
        ht_wr_collision = 1'b0;
        ht_rd_valid     = 1'b0;
        ht_rd_miss      = 1'b0;
        ht_del_done     = 1'b0;
        ht_rd_value     = 32'h5A5A_5A5A;
        if (!rst_n) begin
            pend_cnt = 0;
        end else begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    case (pend_op)
                        2'd1: begin
                            ht_wr_done      = (wr_mode != 2'd1);
                            ht_wr_collision = (wr_mode != 2'd0);
                        end
                        2'd0: begin
                            if (rd_miss_mode) ht_rd_miss = 1'b1;
                            else begin
                                ht_rd_valid = 1'b1;
                                ht_rd_value = rd_data;
                            end
                        end
                        default: ht_del_done = 1'b1;
                    endcase
                end else if (noise) begin
                    ht_wr_done      = (pend_op != 2'd1);
                    ht_wr_collision = (pend_op != 2'd1);
                    ht_rd_valid     = (pend_op != 2'd0);
                    ht_rd_miss      = (pend_op != 2'd0);
                    ht_del_done     = (pend_op != 2'd2);
                end
            end
            if ((int'(ht_wr_en) + int'(ht_rd_en) + int'(ht_del_en)) > 1) multi_strobe++;
            if (ht_wr_en || ht_rd_en || ht_del_en) begin
                strobe_cnt++;
                seen_op  = ht_wr_en ? 2'd1 : (ht_rd_en ? 2'd0 : 2'd2);
                seen_key = ht_key;
                seen_val = ht_value;
                if (!silent) begin
                    pend_op  = seen_op;
                    pend_cnt = noise ? 2 : 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val,
                            input logic [3:0] tag);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_value = val;
        cmd_tag   = tag;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Called right after push_cmd: counts clock edges from the accepting edge.
    task automatic measure_lat(output int lat);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic get_rsp(input string tag, input logic [3:0] etag, input logic [1:0] eop,
                           input logic [1:0] estat, input logic [31:0] eval);
        int n = 0;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"},  {63'd0, rsp_valid}, 64'd1);
        check({tag, "_tag"},    {60'd0, rsp_tag},   {60'd0, etag});
        check({tag, "_op"},     {62'd0, rsp_op},    {62'd0, eop});
        check({tag, "_status"}, {62'd0, rsp_status}, {62'd0, estat});
        check({tag, "_value"},  {32'd0, rsp_value}, {32'd0, eval});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
        check({tag, "_ht_en"}, {61'd0, ht_wr_en, ht_rd_en, ht_del_en}, 64'd0);
        check({tag, "_ht_key"}, {32'd0, ht_key}, 64'd0);
        check({tag, "_ht_value"}, {32'd0, ht_value}, 64'd0);
        check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check({tag, "_rsp_fields"}, {56'd0, rsp_tag, rsp_op, rsp_status}, 64'd0);
        check({tag, "_rsp_value"}, {32'd0, rsp_value}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int lat;
        int s0;
        int seen_rsp;

        // reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {63'd0, cmd_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);

        // WRITE 0x1234 = 0xCAFE, tag 1: minimum latency
        s0 = strobe_cnt;
        push_cmd(2'd1, 32'h1234, 32'hCAFE, 4'd1);
        check("wr_busy", {63'd0, busy}, 64'd1);
        measure_lat(lat);
        check("wr_latency", 64'(lat), 64'd4);
        check("wr_strobes", 64'(strobe_cnt - s0), 64'd1);
        check("wr_seen_op", {62'd0, seen_op}, 64'd1);
        check("wr_seen_key", {32'd0, seen_key}, 64'h1234);
        check("wr_seen_val", {32'd0, seen_val}, 64'hCAFE);
        get_rsp("wr", 4'd1, 2'd1, 2'd0, 32'h0);
        check("wr_idle_busy", {63'd0, busy}, 64'd0);

        // READ hit then READ miss
        rd_data = 32'hCAFE;
        push_cmd(2'd0, 32'h1234, 32'h0, 4'd2);
        get_rsp("rd_hit", 4'd2, 2'd0, 2'd0, 32'hCAFE);
        check("rd_seen_op", {62'd0, seen_op}, 64'd0);
        rd_miss_mode = 1'b1;
        push_cmd(2'd0, 32'h9999, 32'h0, 4'd3);
        get_rsp("rd_miss", 4'd3, 2'd0, 2'd1, 32'h0);
        check("rd_miss_key", {32'd0, seen_key}, 64'h9999);
        rd_miss_mode = 1'b0;

        // DELETE with strobes of other ops arriving first
        noise = 1'b1;
        push_cmd(2'd2, 32'h00AB, 32'h0, 4'd4);
        get_rsp("del_noise", 4'd4, 2'd2, 2'd0, 32'h0);
        noise = 1'b0;

        // WRITE collision only -> FULL; collision with done -> OK
        wr_mode = 2'd1;
        push_cmd(2'd1, 32'h0042, 32'h0077, 4'd5);
        get_rsp("wr_coll", 4'd5, 2'd1, 2'd2, 32'h0);
        wr_mode = 2'd2;
        push_cmd(2'd1, 32'h0043, 32'h0078, 4'd6);
        get_rsp("wr_coll_done", 4'd6, 2'd1, 2'd0, 32'h0);
        wr_mode = 2'd0;

        // illegal op -> ERROR with no strobe
        s0 = strobe_cnt;
        push_cmd(2'd3, 32'h0055, 32'h0066, 4'd7);
        get_rsp("illegal", 4'd7, 2'd3, 2'd3, 32'h0);
        check("illegal_strobes", 64'(strobe_cnt - s0), 64'd0);

        // silent hash table -> ERROR after 8 WAIT cycles, then normal READ
        silent = 1'b1;
        push_cmd(2'd0, 32'h0777, 32'h0, 4'd8);
        measure_lat(lat);
        check("timeout_latency", 64'(lat), 64'd11);
        get_rsp("timeout", 4'd8, 2'd0, 2'd3, 32'h0);
        silent = 1'b0;
        rd_data = 32'h1357_9BDF;
        push_cmd(2'd0, 32'h0778, 32'h0, 4'd9);
        get_rsp("after_timeout", 4'd9, 2'd0, 2'd0, 32'h1357_9BDF);

        // back-pressure: 5 commands, FIFO fills behind the one in flight
        for (int i = 0; i < 5; i++) begin
            push_cmd(2'd1, 32'h100 + 32'(i), 32'h200 + 32'(i), 4'(10 + i));
        end
        check("full_ready_low", {63'd0, cmd_ready}, 64'd0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_tag   = 4'd15;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_hold_ready", {63'd0, cmd_ready}, 64'd0);
            check("full_hold_rsp", {59'd0, rsp_valid, rsp_tag}, {59'd0, 1'b1, 4'd10});
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            get_rsp("order", 4'(10 + i), 2'd1, 2'd0, 32'h0);
        end
        seen_rsp = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp++;
        end
        check("order_no_extra", 64'(seen_rsp), 64'd0);
        check("order_idle", {63'd0, busy}, 64'd0);
        check("no_multi_strobe", 64'(multi_strobe), 64'd0);

        // reset during WAIT with two commands queued
        silent = 1'b1;
        push_cmd(2'd0, 32'h0A, 32'h0, 4'd1);
        push_cmd(2'd0, 32'h0B, 32'h0, 4'd2);
        push_cmd(2'd0, 32'h0C, 32'h0, 4'd3);
        @(negedge clk);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        silent = 1'b0;
        s0 = strobe_cnt;
        seen_rsp = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen_rsp++;
        end
        check("post_reset_quiet", 64'(seen_rsp), 64'd0);
        check("post_reset_strobes", 64'(strobe_cnt - s0), 64'd0);
        push_cmd(2'd1, 32'hBEEF, 32'hF00D, 4'd6);
        measure_lat(lat);
        check("post_reset_latency", 64'(lat), 64'd4);
        get_rsp("post_reset", 4'd6, 2'd1, 2'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
